// File: rtl/keycode_event_fifo.sv
// rtl/keycode_event_fifo.sv - keycode level to press/release event FIFO (optional auto-repeat: KEYCODE_AUTOREPEAT_EN)
module keycode_event_fifo #(
   parameter int DEPTH         = 8,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic                     Clk,
   input  logic                     Reset_h,
   input  logic [7:0]               keycode,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [7:0]               ev_code,
   output logic                     ev_press,
   output logic                     ev_repeat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Parameter sanity: FIFO pointers rely on a power-of-two depth, repeat timers need nonzero periods.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("keycode_event_fifo: DEPTH must be a power of two >= 2 and repeat timings >= 1");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      EMIT_REL   = 2'd1,
      EMIT_PRESS = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    kc_q;
   logic [7:0]    prev, prev_nxt;
   logic [7:0]    pend, pend_nxt;

   logic          fsm_push;
   logic          fsm_press;
   logic [7:0]    fsm_code;

   logic          rep_push;
   logic          push;
   logic [7:0]    push_code;
   logic          push_press;

   logic [7:0]    mem_code  [DEPTH];
   logic          mem_press [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          full, empty, pop, wr_en;
   logic [7:0]    last_code;
   logic          last_press;

   // Input stage: register the PIO level once before edge detection.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) kc_q <= 8'h00;
      else         kc_q <= keycode;
   end

   // FSM state register with the last reported key and the pending new key.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         state <= IDLE;
         prev  <= 8'h00;
         pend  <= 8'h00;
      end else begin
         state <= state_nxt;
         prev  <= prev_nxt;
         pend  <= pend_nxt;
      end
   end

   // FSM next-state: a level change becomes a release of the old key then a press of the new one.
   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      pend_nxt  = pend;
      fsm_push  = 1'b0;
      fsm_press = 1'b0;
      fsm_code  = 8'h00;
      case (state)
         IDLE: begin
            if (kc_q != prev) begin
               pend_nxt  = kc_q;
               state_nxt = (prev != 8'h00) ? EMIT_REL : EMIT_PRESS;
            end
         end
         EMIT_REL: begin
            fsm_push  = 1'b1;
            fsm_code  = prev;
            prev_nxt  = 8'h00;
            state_nxt = (pend != 8'h00) ? EMIT_PRESS : IDLE;
         end
         EMIT_PRESS: begin
            fsm_push  = 1'b1;
            fsm_press = 1'b1;
            fsm_code  = pend;
            prev_nxt  = pend;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef KEYCODE_AUTOREPEAT_EN
   logic [31:0] rep_cnt;
   logic        rep_armed;
   logic        rep_run;
   logic        rep_fire;
   logic        push_rep;
   logic        mem_rep [DEPTH];
   logic        last_rep;

   // The timer only runs while a key is steadily held and the FSM is idle.
   assign rep_run  = (state == IDLE) && (prev != 8'h00) && (kc_q == prev);
   assign rep_fire = rep_run && (rep_cnt == (rep_armed ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1)));
   assign rep_push = rep_fire && !fsm_push;
   assign push_rep = !fsm_push && rep_push;

   // Repeat timer: restart on each real press, first interval is the delay, then the period.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         rep_cnt   <= 32'd0;
         rep_armed <= 1'b0;
      end else if ((fsm_push && fsm_press) || !rep_run) begin
         rep_cnt   <= 32'd0;
         rep_armed <= 1'b0;
      end else if (rep_fire) begin
         rep_cnt   <= 32'd0;
         rep_armed <= 1'b1;
      end else begin
         rep_cnt   <= rep_cnt + 32'd1;
      end
   end

   // Repeat flag storage alongside the event payload.
   always_ff @(posedge Clk) begin
      if (wr_en) mem_rep[wr_ptr] <= push_rep;
   end

   // Holds the repeat flag of the last popped event for display while empty.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h)  last_rep <= 1'b0;
      else if (pop) last_rep <= mem_rep[rd_ptr];
   end

   assign ev_repeat = empty ? last_rep : mem_rep[rd_ptr];
`else
   assign rep_push  = 1'b0;
   assign ev_repeat = 1'b0;
`endif

   // FSM events take priority; repeats always re-press the held key.
   assign push       = fsm_push || rep_push;
   assign push_code  = fsm_push ? fsm_code  : prev;
   assign push_press = fsm_push ? fsm_press : 1'b1;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign pop   = !empty && ev_ready;
   assign wr_en = push && (!full || pop);

   // Payload storage; no reset needed because empty entries are never shown.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem_code[wr_ptr]  <= push_code;
         mem_press[wr_ptr] <= push_press;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Keeps the last popped head so outputs hold steady while the FIFO is empty.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         last_code  <= 8'h00;
         last_press <= 1'b0;
      end else if (pop) begin
         last_code  <= mem_code[rd_ptr];
         last_press <= mem_press[rd_ptr];
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h)                    overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
      else if (clr_overflow)          overflow <= 1'b0;
   end

   assign ev_valid = !empty;
   assign ev_code  = empty ? last_code  : mem_code[rd_ptr];
   assign ev_press = empty ? last_press : mem_press[rd_ptr];
   assign count    = cnt_q;

endmodule

// File: tb/tb_keycode_event_fifo.sv
// tb/tb_keycode_event_fifo.sv - scoreboard bench for keycode_event_fifo
module tb_keycode_event_fifo;

   logic       Clk = 1'b0;
   logic       Reset_h;
   logic [7:0] keycode;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_press;
   logic       ev_repeat;
   logic [3:0] count;
   logic       overflow;
   logic       clr_overflow;

   typedef struct packed {
      logic [7:0] code;
      logic       press;
      logic       rep;
   } ev_t;

   ev_t        sb[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] model_prev = 8'h00;

   keycode_event_fifo #(.DEPTH(8), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut (
      .Clk          (Clk),
      .Reset_h      (Reset_h),
      .keycode      (keycode),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_code      (ev_code),
      .ev_press     (ev_press),
      .ev_repeat    (ev_repeat),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic expect_push(input logic [7:0] code, input logic press, input logic rep);
      ev_t e;
      e.code  = code;
      e.press = press;
      e.rep   = rep;
      if (sb.size() < 8) sb.push_back(e);
   endtask

   task automatic key_change(input logic [7:0] k);
      @(posedge Clk);
      #1 keycode = k;
      if (model_prev != 8'h00) expect_push(model_prev, 1'b0, 1'b0);
      if (k != 8'h00)          expect_push(k, 1'b1, 1'b0);
      model_prev = k;
      repeat (4) @(posedge Clk);
   endtask

   task automatic sb_pop_compare(input string name);
      ev_t exp;
      @(negedge Clk);
      n_checks++;
      if (sb.size() == 0) begin
         $display("FAIL %s: got valid=%0b code=%02h with empty scoreboard, want an expected event", name, ev_valid, ev_code);
      end else begin
         exp = sb.pop_front();
         if ({ev_valid, ev_code, ev_press, ev_repeat} !== {1'b1, exp.code, exp.press, exp.rep})
            $display("FAIL %s: got v=%0b code=%02h press=%0b rep=%0b want v=1 code=%02h press=%0b rep=%0b",
                     name, ev_valid, ev_code, ev_press, ev_repeat, exp.code, exp.press, exp.rep);
         else
            n_pass++;
      end
      ev_ready = 1'b1;
      @(posedge Clk);
      #1 ev_ready = 1'b0;
   endtask

   task automatic test_reset();
      Reset_h = 1'b1; keycode = 8'h00; ev_ready = 1'b0; clr_overflow = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if ({ev_valid, ev_code, ev_press, ev_repeat, count, overflow} !== 16'h0000)
         $display("FAIL reset_state: got v=%0b code=%02h p=%0b r=%0b cnt=%0d ovf=%0b want all zero",
                  ev_valid, ev_code, ev_press, ev_repeat, count, overflow);
      else n_pass++;
      @(posedge Clk);
      #1 Reset_h = 1'b0;
      model_prev = 8'h00;
   endtask

   task automatic test_press();
      @(posedge Clk);
      #1 keycode = 8'h04;
      expect_push(8'h04, 1'b1, 1'b0);
      model_prev = 8'h04;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if (ev_valid !== 1'b0) $display("FAIL press_early: got valid=%0b want 0 at k+1", ev_valid);
      else n_pass++;
      @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if ({ev_valid, count} !== {1'b1, 4'd1}) $display("FAIL press_latency: got valid=%0b cnt=%0d want 1/1", ev_valid, count);
      else n_pass++;
      sb_pop_compare("press_04");
      @(negedge Clk);
      n_checks++;
      if (count !== 4'd0) $display("FAIL press_popped: got cnt=%0d want 0", count);
      else n_pass++;
   endtask

   task automatic test_release_press();
      @(posedge Clk);
      #1 keycode = 8'h1A;
      expect_push(8'h04, 1'b0, 1'b0);
      expect_push(8'h1A, 1'b1, 1'b0);
      model_prev = 8'h1A;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if ({count, ev_code, ev_press} !== {4'd1, 8'h04, 1'b0})
         $display("FAIL rel_k2: got cnt=%0d code=%02h p=%0b want 1 04 0", count, ev_code, ev_press);
      else n_pass++;
      @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if (count !== 4'd2) $display("FAIL press_k3: got cnt=%0d want 2", count);
      else n_pass++;
      sb_pop_compare("rel_04");
      sb_pop_compare("press_1a");
   endtask

   task automatic test_overflow();
      logic [7:0] seq [9];
      seq = '{8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00};
      for (int i = 0; i < 9; i++) key_change(seq[i]);
      @(negedge Clk);
      n_checks++;
      if ({count, overflow, ev_code, ev_press} !== {4'd8, 1'b1, 8'h1A, 1'b0})
         $display("FAIL ovf_full: got cnt=%0d ovf=%0b head=%02h/%0b want 8 1 1a/0", count, overflow, ev_code, ev_press);
      else n_pass++;
      @(posedge Clk);
      #1 keycode = 8'h09;
      expect_push(8'h09, 1'b1, 1'b0);
      model_prev = 8'h09;
      @(posedge Clk);
      @(posedge Clk);
      #1 clr_overflow = 1'b1;
      @(posedge Clk);
      #1 clr_overflow = 1'b0;
      @(negedge Clk);
      n_checks++;
      if ({overflow, count} !== {1'b1, 4'd8}) $display("FAIL ovf_set_wins: got ovf=%0b cnt=%0d want 1 8", overflow, count);
      else n_pass++;
      @(posedge Clk);
      #1 clr_overflow = 1'b1;
      @(posedge Clk);
      #1 clr_overflow = 1'b0;
      @(negedge Clk);
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL ovf_clear: got ovf=%0b want 0", overflow);
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      ev_t exp;
      @(posedge Clk);
      #1 keycode = 8'h00;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      exp = sb.pop_front();
      n_checks++;
      if ({ev_code, ev_press} !== {exp.code, exp.press})
         $display("FAIL full_pop_head: got %02h/%0b want %02h/%0b", ev_code, ev_press, exp.code, exp.press);
      else n_pass++;
      ev_ready = 1'b1;
      expect_push(8'h09, 1'b0, 1'b0);
      model_prev = 8'h00;
      @(posedge Clk);
      #1 ev_ready = 1'b0;
      @(negedge Clk);
      n_checks++;
      if ({count, overflow} !== {4'd8, 1'b0}) $display("FAIL full_push_pop: got cnt=%0d ovf=%0b want 8 0", count, overflow);
      else n_pass++;
      for (int i = 0; i < 8; i++) sb_pop_compare("drain_full");
      @(negedge Clk);
      n_checks++;
      if ({count, ev_valid} !== {4'd0, 1'b0}) $display("FAIL drain_empty: got cnt=%0d v=%0b want 0 0", count, ev_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      key_change(8'h0A);
      key_change(8'h0B);
      @(negedge Clk);
      n_checks++;
      if (count !== 4'd3) $display("FAIL pre_reset_count: got cnt=%0d want 3", count);
      else n_pass++;
      @(posedge Clk);
      #1 keycode = 8'h0C;
      @(posedge Clk);
      @(posedge Clk);
      #1 Reset_h = 1'b1;
      #1;
      n_checks++;
      if ({count, ev_valid, ev_code} !== {4'd0, 1'b0, 8'h00})
         $display("FAIL reset_async: got cnt=%0d v=%0b code=%02h want 0 0 00", count, ev_valid, ev_code);
      else n_pass++;
      sb.delete();
      keycode = 8'h07;
      model_prev = 8'h00;
      repeat (2) @(posedge Clk);
      #1 Reset_h = 1'b0;
      expect_push(8'h07, 1'b1, 1'b0);
      model_prev = 8'h07;
      for (int i = 0; i < 10 && !ev_valid; i++) @(negedge Clk);
      n_checks++;
      if (ev_valid !== 1'b1) $display("FAIL press_after_reset: got v=%0b want 1 within 10 cycles", ev_valid);
      else n_pass++;
      sb_pop_compare("press_07");
   endtask

`ifdef KEYCODE_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int push_t[$];
      int last;
      keycode = 8'h00;
      ev_ready = 1'b1;
      repeat (30) @(posedge Clk);
      #1 ev_ready = 1'b0;
      sb.delete();
      model_prev = 8'h00;
      @(negedge Clk);
      n_checks++;
      if (count !== 4'd0) $display("FAIL rep_flush: got cnt=%0d want 0", count);
      else n_pass++;
      @(posedge Clk);
      #1 keycode = 8'h16;
      expect_push(8'h16, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) expect_push(8'h16, 1'b1, 1'b1);
      expect_push(8'h16, 1'b0, 1'b0);
      last = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge Clk);
         if (int'(count) > last) push_t.push_back(t);
         last = int'(count);
         if (push_t.size() == 4 && keycode != 8'h00) keycode = 8'h00;
      end
      n_checks++;
      if (push_t.size() != 5) $display("FAIL rep_push_count: got %0d pushes want 5", push_t.size());
      else begin
         n_pass++;
         n_checks++;
         if (push_t[1] - push_t[0] != 10) $display("FAIL rep_first: got +%0d want +10", push_t[1] - push_t[0]);
         else n_pass++;
         n_checks++;
         if (push_t[2] - push_t[0] != 14) $display("FAIL rep_second: got +%0d want +14", push_t[2] - push_t[0]);
         else n_pass++;
         n_checks++;
         if (push_t[3] - push_t[0] != 18) $display("FAIL rep_third: got +%0d want +18", push_t[3] - push_t[0]);
         else n_pass++;
         n_checks++;
         if (push_t[4] - push_t[0] != 21) $display("FAIL rep_release: got +%0d want +21", push_t[4] - push_t[0]);
         else n_pass++;
      end
      for (int i = 0; i < 5; i++) sb_pop_compare("rep_drain");
   endtask
`endif

   initial begin
      test_reset();
      test_press();
      test_release_press();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
`ifdef KEYCODE_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
